// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit feeding the instruction queue.
//
// Holds the fetch PC and issues one 32-bit read at a time to the memory
// controller. Each returned word is pushed to the queue together with its PC.
// A redirect replaces the fetch PC. A read that is still outstanding when the
// redirect arrives is marked stale. Its data is dropped when it returns.
//
// Optional feature: define IFETCH_ICACHE_EN to add a direct-mapped icache of
// 2^ICACHE_IDX_W one-word lines. A hit delivers from IDLE without a memory read.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   rdy                 global enable, low freezes all state (inst_rdy forced 0)
//   iq_full             queue full flag, checked only when launching a read
//   inst_rdy/inst/pc_out  one-cycle push strobe, instruction word and its PC
//   mem_req/mem_addr    level read request and its word-aligned address
//   mem_done/mem_data   one-cycle read completion and returned word
//   redirect_vld/redirect_pc  one-cycle fetch PC redirect
module ifetch #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          ICACHE_IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        iq_full,
   output logic        inst_rdy,
   output logic [31:0] inst,
   output logic [31:0] pc_out,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   input  logic        redirect_vld,
   input  logic [31:0] redirect_pc
);

   // The tag slice pc[31:ICACHE_IDX_W+2] must be a legal, non-empty range.
   if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > 16) begin : g_bad_idx
      $error("ifetch: ICACHE_IDX_W must be within 1..16");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no read outstanding
      WAIT = 2'd1,   // read outstanding, its data will be delivered
      DROP = 2'd2    // read outstanding, a redirect made it stale
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] inst_nxt, pc_out_nxt, mem_addr_nxt;
   logic        inst_rdy_nxt, mem_req_nxt;
   logic        cache_hit;
   logic [31:0] cache_data;

`ifdef IFETCH_ICACHE_EN
   localparam int LINES = 1 << ICACHE_IDX_W;
   localparam int TAG_W = 30 - ICACHE_IDX_W;

   logic [LINES-1:0]        line_vld;
   logic [TAG_W-1:0]        line_tag  [LINES];
   logic [31:0]             line_data [LINES];
   logic [ICACHE_IDX_W-1:0] rd_idx, wr_idx;
   logic                    fill;

   assign rd_idx     = pc[ICACHE_IDX_W+1:2];
   assign wr_idx     = mem_addr[ICACHE_IDX_W+1:2];
   assign cache_hit  = line_vld[rd_idx] && (line_tag[rd_idx] == pc[31:ICACHE_IDX_W+2]);
   assign cache_data = line_data[rd_idx];
   // Every completed read fills its line, including stale responses: the
   // word is still correct for mem_addr even though it is not delivered.
   assign fill       = mem_done && (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_vld <= '0;
      end else if (rdy && fill) begin
         line_vld[wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays are not reset; the valid bits gate every read.
   always_ff @(posedge clk) begin
      if (rst_n && rdy && fill) begin
         line_tag[wr_idx]  <= mem_addr[31:ICACHE_IDX_W+2];
         line_data[wr_idx] <= mem_data;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_data = '0;
`endif

   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case infers a latch.
      state_nxt    = state;
      pc_nxt       = pc;
      inst_nxt     = inst;
      pc_out_nxt   = pc_out;
      mem_req_nxt  = mem_req;
      mem_addr_nxt = mem_addr;
      inst_rdy_nxt = 1'b0;

      unique case (state)
         IDLE: begin
            if (redirect_vld) begin
               pc_nxt = redirect_pc;
            end else if (!iq_full) begin
               if (cache_hit) begin
                  inst_rdy_nxt = 1'b1;
                  inst_nxt     = cache_data;
                  pc_out_nxt   = pc;
                  pc_nxt       = pc + 32'd4;
               end else begin
                  mem_req_nxt  = 1'b1;
                  mem_addr_nxt = pc;
                  state_nxt    = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_done) begin
               mem_req_nxt = 1'b0;
               state_nxt   = IDLE;
               // A redirect in the completion cycle wins over delivery.
               if (redirect_vld) begin
                  pc_nxt = redirect_pc;
               end else begin
                  inst_rdy_nxt = 1'b1;
                  inst_nxt     = mem_data;
                  pc_out_nxt   = mem_addr;
                  pc_nxt       = pc + 32'd4;
               end
            end else if (redirect_vld) begin
               pc_nxt    = redirect_pc;
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (redirect_vld) begin
               pc_nxt = redirect_pc;
            end
            if (mem_done) begin
               mem_req_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         inst_rdy <= 1'b0;
         inst     <= '0;
         pc_out   <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (rdy) begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         inst_rdy <= inst_rdy_nxt;
         inst     <= inst_nxt;
         pc_out   <= pc_out_nxt;
         mem_req  <= mem_req_nxt;
         mem_addr <= mem_addr_nxt;
      end else begin
         inst_rdy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch.
// A transaction-level model tracks the fetch PC, the outstanding read and
// whether a redirect made that read stale. The model predicts every output on
// every cycle. Directed phases pin the model with hand-computed values. A
// randomized phase then exercises reset, rdy, iq_full, redirects and memory
// latency.
module tb_ifetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          IDX_W    = 4;
   localparam int          LINES    = 1 << IDX_W;

   logic        clk = 1'b0;
   logic        rst_n, rdy, iq_full, redirect_vld;
   logic [31:0] redirect_pc;
   logic        mem_done = 1'b0;
   logic [31:0] mem_data = '0;
   logic        inst_rdy, mem_req;
   logic [31:0] inst, pc_out, mem_addr;

   int total  = 0;
   int passed = 0;

   ifetch #(.RESET_PC(RESET_PC), .ICACHE_IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .iq_full(iq_full),
      .inst_rdy(inst_rdy), .inst(inst), .pc_out(pc_out),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_done(mem_done), .mem_data(mem_data),
      .redirect_vld(redirect_vld), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Memory contents: address 0 holds a NOP, everything else is a hash of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // ---------------- memory responder ----------------
   int fixed_lat = 3;     // 0 selects a random latency of 1..4
   bit stray_en  = 1'b0;  // occasional mem_done with no request outstanding
   bit busy      = 1'b0;
   int busy_cnt  = 0;

   always @(negedge clk) begin
      if (mem_done) begin
         mem_done = 1'b0;
         busy     = 1'b0;
      end else if (mem_req === 1'b1) begin
         if (!busy) begin
            busy     = 1'b1;
            busy_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
         end else begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               mem_done = 1'b1;
               mem_data = mem_word(mem_addr);
            end
         end
      end else begin
         busy = 1'b0;
         if (stray_en && $urandom_range(0, 19) == 0) begin
            mem_done = 1'b1;
            mem_data = $urandom;
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   bit          m_on = 1'b0;
   logic [31:0] m_pc, m_addr, m_inst, m_pc_out;
   bit          m_pend, m_stale, m_push;
   bit          m_line_vld  [LINES];
   logic [31:0] m_line_addr [LINES];

   function automatic bit m_hit(input logic [31:0] a);
`ifdef IFETCH_ICACHE_EN
      return m_line_vld[a[IDX_W+1:2]] && m_line_addr[a[IDX_W+1:2]] == a;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         m_on = 1'b1; m_pc = RESET_PC; m_pend = 0; m_stale = 0; m_push = 0;
         m_addr = '0; m_inst = '0; m_pc_out = '0;
         for (int i = 0; i < LINES; i++) m_line_vld[i] = 1'b0;
      end else if (m_on) begin
         m_push = 1'b0;
         if (rdy) begin
            if (!m_pend) begin
               if (redirect_vld) m_pc = redirect_pc;
               else if (!iq_full) begin
                  if (m_hit(m_pc)) begin
                     m_push = 1; m_inst = mem_word(m_pc); m_pc_out = m_pc; m_pc = m_pc + 32'd4;
                  end else begin
                     m_pend = 1; m_stale = 0; m_addr = m_pc;
                  end
               end
            end else begin
               if (mem_done) begin
                  m_line_vld[m_addr[IDX_W+1:2]]  = 1'b1;
                  m_line_addr[m_addr[IDX_W+1:2]] = m_addr;
                  if (!m_stale && !redirect_vld) begin
                     m_push = 1; m_inst = mem_word(m_addr); m_pc_out = m_addr; m_pc = m_addr + 32'd4;
                  end
                  m_pend = 0;
               end else if (redirect_vld) begin
                  m_stale = 1;
               end
               if (redirect_vld) m_pc = redirect_pc;
            end
         end
      end
      #1;
      if (m_on) begin
         check("cyc_inst_rdy", inst_rdy, m_push);
         check("cyc_mem_req", mem_req, m_pend);
         check("cyc_mem_addr", mem_addr, m_addr);
         check("cyc_inst", inst, m_inst);
         check("cyc_pc_out", pc_out, m_pc_out);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_push(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (inst_rdy) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (mem_req) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   initial begin
      bit          ok;
      int          pushes;
      logic [31:0] held;

      rst_n = 1'b0; rdy = 1'b1; iq_full = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
      tick(); tick();
      check("reset_inst_rdy", inst_rdy, 0);
      check("reset_mem_req", mem_req, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_pc_out", pc_out, 0);
      check("reset_inst", inst, 0);

      // First fetch after reset, memory latency 3.
      rst_n = 1'b1;
      tick();
      check("first_req", mem_req, 1);
      check("first_addr", mem_addr, 32'h0);
      repeat (4) tick();
      check("first_push", inst_rdy, 1);
      check("first_pc_out", pc_out, 32'h0);
      check("first_inst", inst, 32'h0000_0013);
      tick();
      check("second_req", mem_req, 1);
      check("second_addr", mem_addr, 32'h4);

      // iq_full held from reset blocks the launch.
      rst_n = 1'b0; iq_full = 1'b1;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("full_no_req", mem_req, 0);
      iq_full = 1'b0;
      tick();
      check("full_release_req", mem_req, 1);

      // Redirect in the same cycle as the completion of the read for address 8.
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (mem_done && mem_addr == 32'h8) begin ok = 1'b1; break; end
         tick();
      end
      check("done8_seen", ok, 1);
      redirect_vld = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_vld = 1'b0;
      check("redir_done_no_push", inst_rdy, 0);
      tick();
      check("redir_done_req", mem_req, 1);
      check("redir_done_addr", mem_addr, 32'h100);

      // Redirect two cycles before completion: the stale word is never pushed.
      tick();
      redirect_vld = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_vld = 1'b0;
      ok = 1'b0; pushes = 0;
      for (int i = 0; i < 50; i++) begin
         if (inst_rdy) pushes++;
         if (mem_req && mem_addr == 32'h200) begin ok = 1'b1; break; end
         tick();
      end
      check("stale_req_200", ok, 1);
      check("stale_no_push", pushes, 0);
      wait_push(ok);
      check("stale_push_seen", ok, 1);
      check("stale_next_pc_out", pc_out, 32'h200);

      // PC wrap at the top of the address space.
      redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_vld = 1'b0;
      wait_push(ok);
      check("wrap_push_seen", ok, 1);
      check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
      wait_req(ok);
      check("wrap_req_seen", ok, 1);
      check("wrap_next_addr", mem_addr, 32'h0);

      // rdy low in the middle of a read freezes the address and suppresses pushes.
      held = mem_addr;
      rdy = 1'b0;
      pushes = 0;
      repeat (6) begin
         tick();
         if (mem_addr !== held) pushes++;
         if (inst_rdy) pushes++;
      end
      check("frozen_changes", pushes, 0);
      rdy = 1'b1;
      wait_push(ok);
      check("unfreeze_push_seen", ok, 1);
      check("unfreeze_pc_out", pc_out, held);

`ifdef IFETCH_ICACHE_EN
      // Loop of 4 instructions at 0x40: later passes must be served by the cache.
      redirect_vld = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_vld = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (inst_rdy && pc_out == 32'h4C) begin ok = 1'b1; break; end
         tick();
      end
      check("loop_first_pass", ok, 1);
      for (int pass = 0; pass < 2; pass++) begin
         redirect_vld = 1'b1; redirect_pc = 32'h40;
         tick();
         redirect_vld = 1'b0;
         tick();
         for (int k = 0; k < 4; k++) begin
            check("loop_hit_push", inst_rdy, 1);
            check("loop_hit_no_req", mem_req, 0);
            check("loop_hit_pc_out", pc_out, 32'h40 + 32'(4 * k));
            if (k < 3) tick();
         end
      end
`endif

      // Randomized phase.
      fixed_lat = 0;
      stray_en  = 1'b1;
      repeat (4000) begin
         rst_n        = ($urandom_range(0, 299) != 0);
         rdy          = !rst_n || ($urandom_range(0, 9) != 0);
         iq_full      = ($urandom_range(0, 9) < 3);
         redirect_vld = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = 32'h40;
            1:       redirect_pc = 32'hFFFF_FFF8;
            2:       redirect_pc = 32'h100;
            default: redirect_pc = $urandom & 32'h0000_0FFC;
         endcase
         tick();
      end
      rst_n = 1'b1; rdy = 1'b1; iq_full = 1'b0; redirect_vld = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
